// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings for the clock time-setting controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_SET_SEC = 2'b11
  } mode_t;

  // Mode sequence advanced by each ModeKey press.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    unique case (m)
      MODE_RUN:     r = MODE_SET_HR;
      MODE_SET_HR:  r = MODE_SET_MIN;
      MODE_SET_MIN: r = MODE_SET_SEC;
      MODE_SET_SEC: r = MODE_RUN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one debounced key.
module key_sync_edge (
  input  logic CP,
  input  logic CR,
  input  logic KeyIn,
  output logic Level,
  output logic Rise
);

  logic sync1, sync2, prev;
  logic [1:0] vld;

  // Synchronizer chain; prev is held high until the chain carries a real sample,
  // so a key held through reset does not look like a fresh press.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      vld   <= 2'b00;
    end else begin
      sync1 <= KeyIn;
      sync2 <= sync1;
      prev  <= vld[1] ? sync2 : 1'b1;
      vld   <= {vld[0], 1'b1};
    end
  end

  assign Level = sync2;
  assign Rise  = sync2 & ~prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode FSM for the digital clock: mode stepping, increment strobes with
// auto-repeat, idle timeout back to RUN, and registered panel outputs.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_TICKS    = 4,
  parameter int unsigned REPEAT_TICKS  = 1,
  parameter int unsigned TIMEOUT_TICKS = 40,
  parameter int unsigned CW            = 6
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       Tick,
  input  logic       ModeKey,
  input  logic       IncKey,
  output logic [1:0] Mode,
  output logic       IncHr,
  output logic       IncMin,
  output logic       ClrSec,
  output logic       Run,
  output logic       Blink
);

  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [CW-1:0] HoldMax = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] IdleMax = CW'(TIMEOUT_TICKS);
  localparam logic [RW-1:0] RepMax  = RW'(REPEAT_TICKS);

  logic mode_lvl, mode_rise, inc_lvl, inc_rise;

  key_sync_edge u_mode_key (
    .CP    (CP),
    .CR    (CR),
    .KeyIn (ModeKey),
    .Level (mode_lvl),
    .Rise  (mode_rise)
  );

  key_sync_edge u_inc_key (
    .CP    (CP),
    .CR    (CR),
    .KeyIn (IncKey),
    .Level (inc_lvl),
    .Rise  (inc_rise)
  );

  mode_t         mode_q, mode_d;
  logic [CW-1:0] hold_q, hold_d, idle_q, idle_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          armed_q, armed_d;
  logic          inc_hr_q, inc_hr_d, inc_min_q, inc_min_d, clr_sec_q, clr_sec_d;
  logic          run_q, run_d, blink_q, blink_d;

  logic          strobe, timeout, in_set, rep_mode;
  logic [CW-1:0] hold_inc, idle_inc;
  logic [RW-1:0] rep_inc;

  assign hold_inc = hold_q + CW'(1);
  assign idle_inc = idle_q + CW'(1);
  assign rep_inc  = rep_q + RW'(1);

  // Next-state for FSM, hold/repeat/idle counters and registered outputs.
  always_comb begin
    mode_d    = mode_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    idle_d    = idle_q;
    armed_d   = armed_q;
    strobe    = 1'b0;
    timeout   = 1'b0;
    in_set    = (mode_q != MODE_RUN);
    rep_mode  = (mode_q == MODE_SET_HR) || (mode_q == MODE_SET_MIN);

    // Idle counter: only counts with both keys released, cleared by any activity.
    if (!in_set || mode_rise || inc_rise || inc_lvl) begin
      idle_d = '0;
    end else if (!mode_lvl && Tick) begin
      if (idle_inc >= IdleMax) begin
        timeout = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_inc;
      end
    end

    // Hold/repeat: armed only by an Inc press inside a repeat-capable mode, so a
    // key carried across a mode change stays inert until re-pressed.
    if (mode_rise) begin
      hold_d  = '0;
      rep_d   = '0;
      armed_d = 1'b0;
    end else if (inc_rise) begin
      hold_d  = '0;
      rep_d   = '0;
      armed_d = rep_mode;
      strobe  = in_set;
    end else if (!inc_lvl) begin
      hold_d  = '0;
      rep_d   = '0;
      armed_d = 1'b0;
    end else if (armed_q && Tick) begin
      if (hold_q < HoldMax) begin
        hold_d = hold_inc;
        strobe = (hold_inc == HoldMax);
      end else if (rep_inc >= RepMax) begin
        strobe = 1'b1;
        rep_d  = '0;
      end else begin
        rep_d = rep_inc;
      end
    end

    if (mode_rise) begin
      mode_d = next_mode(mode_q);
    end else if (timeout) begin
      mode_d = MODE_RUN;
    end

    inc_hr_d  = strobe && (mode_q == MODE_SET_HR);
    inc_min_d = strobe && (mode_q == MODE_SET_MIN);
    clr_sec_d = strobe && (mode_q == MODE_SET_SEC);
    run_d     = (mode_d != MODE_SET_SEC);

    if (mode_d == MODE_RUN) begin
      blink_d = 1'b0;
    end else if (mode_d != mode_q) begin
      blink_d = 1'b1;
    end else if (Tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      mode_q    <= MODE_RUN;
      hold_q    <= '0;
      rep_q     <= '0;
      idle_q    <= '0;
      armed_q   <= 1'b0;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      clr_sec_q <= 1'b0;
      run_q     <= 1'b1;
      blink_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      idle_q    <= idle_d;
      armed_q   <= armed_d;
      inc_hr_q  <= inc_hr_d;
      inc_min_q <= inc_min_d;
      clr_sec_q <= clr_sec_d;
      run_q     <= run_d;
      blink_q   <= blink_d;
    end
  end

  assign Mode   = mode_q;
  assign IncHr  = inc_hr_q;
  assign IncMin = inc_min_q;
  assign ClrSec = clr_sec_q;
  assign Run    = run_q;
  assign Blink  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: scoreboard of expected strobes checked by a monitor,
// plus per-scenario inline checks of mode, run and blink.
module tb_clock_set_ctrl;

  logic       CP = 1'b0;
  logic       CR, Tick, ModeKey, IncKey;
  logic [1:0] Mode;
  logic       IncHr, IncMin, ClrSec, Run, Blink;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int mon_got, mon_exp, mon_sum;

  localparam int SHr  = 1;
  localparam int SMin = 2;
  localparam int SSec = 3;

  always #5 CP = ~CP;

  clock_set_ctrl #(
    .HOLD_TICKS    (4),
    .REPEAT_TICKS  (1),
    .TIMEOUT_TICKS (40),
    .CW            (6)
  ) dut (
    .CP      (CP),
    .CR      (CR),
    .Tick    (Tick),
    .ModeKey (ModeKey),
    .IncKey  (IncKey),
    .Mode    (Mode),
    .IncHr   (IncHr),
    .IncMin  (IncMin),
    .ClrSec  (ClrSec),
    .Run     (Run),
    .Blink   (Blink)
  );

  // Strobe monitor: every strobe seen must match the next expected entry.
  always @(negedge CP) begin
    if (!CR && (IncHr || IncMin || ClrSec)) begin
      mon_sum = int'(IncHr) + int'(IncMin) + int'(ClrSec);
      mon_got = IncHr ? SHr : (IncMin ? SMin : SSec);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected got=%0d (hr/min/sec=1/2/3) required none at %0t",
                 mon_got, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp || mon_sum != 1) begin
          n_err++;
          $display("FAIL strobe_kind got=%0d count=%0d required=%0d at %0t",
                   mon_got, mon_sum, mon_exp, $time);
        end
      end
    end
  end

  // Advance n clocks and land 1ns after the last rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      Tick = 1'b1;
      cyc(1);
      Tick = 1'b0;
      cyc(3);
    end
  endtask

  task automatic mode_down();
    ModeKey = 1'b1;
    cyc(3);
  endtask

  task automatic mode_up();
    ModeKey = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    CR = 1'b1; Tick = 1'b0; ModeKey = 1'b0; IncKey = 1'b0;
    cyc(2);
    CR = 1'b0;
    cyc(1);
    n_cmp++; if (Mode !== 2'b00) begin n_err++; $display("FAIL reset_mode got=%b required=00", Mode); end
    n_cmp++; if (Run !== 1'b1) begin n_err++; $display("FAIL reset_run got=%b required=1", Run); end
    n_cmp++; if (Blink !== 1'b0) begin n_err++; $display("FAIL reset_blink got=%b required=0", Blink); end
    n_cmp++;
    if ({IncHr, IncMin, ClrSec} !== 3'b000) begin
      n_err++; $display("FAIL reset_strobes got=%b required=000", {IncHr, IncMin, ClrSec});
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [4];
    exp_mode[0] = 2'b01; exp_mode[1] = 2'b10; exp_mode[2] = 2'b11; exp_mode[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      mode_down();
      n_cmp++;
      if (Mode !== exp_mode[i]) begin
        n_err++; $display("FAIL cycle_mode step=%0d got=%b required=%b", i, Mode, exp_mode[i]);
      end
      n_cmp++;
      if (Run !== (exp_mode[i] != 2'b11)) begin
        n_err++; $display("FAIL cycle_run step=%0d got=%b required=%b", i, Run,
                          exp_mode[i] != 2'b11);
      end
      n_cmp++;
      if (Blink !== (exp_mode[i] != 2'b00)) begin
        n_err++; $display("FAIL cycle_blink step=%0d got=%b required=%b", i, Blink,
                          exp_mode[i] != 2'b00);
      end
      mode_up();
    end
  endtask

  task automatic test_single_inc();
    // Inc in RUN is ignored: nothing queued, monitor flags any strobe.
    IncKey = 1'b1; cyc(4); IncKey = 1'b0; cyc(4);
    mode_down(); mode_up();
    mode_down(); mode_up();
    n_cmp++; if (Mode !== 2'b10) begin n_err++; $display("FAIL single_mode got=%b required=10", Mode); end
    IncKey = 1'b1;
    exp_q.push_back(SMin);
    cyc(2);
    n_cmp++; if (IncMin !== 1'b0) begin n_err++; $display("FAIL single_early got=%b required=0", IncMin); end
    cyc(1);
    n_cmp++;
    if ({IncHr, IncMin, ClrSec} !== 3'b010) begin
      n_err++; $display("FAIL single_pulse got=%b required=010", {IncHr, IncMin, ClrSec});
    end
    cyc(1);
    n_cmp++; if (IncMin !== 1'b0) begin n_err++; $display("FAIL single_width got=%b required=0", IncMin); end
    IncKey = 1'b0;
    cyc(4);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_pending got=%0d required=0", exp_q.size()); end
    mode_down(); mode_up();
    mode_down(); mode_up();
  endtask

  task automatic test_auto_repeat();
    mode_down(); mode_up();
    n_cmp++; if (Mode !== 2'b01) begin n_err++; $display("FAIL repeat_mode got=%b required=01", Mode); end
    IncKey = 1'b1;
    exp_q.push_back(SHr);
    cyc(4);
    for (int i = 0; i < 7; i++) exp_q.push_back(SHr);
    ticks(10);
    IncKey = 1'b0;
    cyc(4);
    ticks(3);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL repeat_missing got=%0d required=0", exp_q.size()); end
    n_cmp++; if (Mode !== 2'b01) begin n_err++; $display("FAIL repeat_mode_end got=%b required=01", Mode); end
  endtask

  task automatic test_simultaneous();
    ModeKey = 1'b1;
    IncKey  = 1'b1;
    cyc(3);
    n_cmp++; if (Mode !== 2'b10) begin n_err++; $display("FAIL simul_mode got=%b required=10", Mode); end
    ModeKey = 1'b0;
    cyc(4);
    ticks(20);
    n_cmp++; if (Mode !== 2'b10) begin n_err++; $display("FAIL simul_hold_mode got=%b required=10", Mode); end
    IncKey = 1'b0;
    cyc(4);
    // A fresh press now acts normally.
    exp_q.push_back(SMin);
    IncKey = 1'b1; cyc(4); IncKey = 1'b0; cyc(4);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL simul_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    mode_down(); mode_up();
    n_cmp++; if (Mode !== 2'b11) begin n_err++; $display("FAIL tmo_mode got=%b required=11", Mode); end
    exp_q.push_back(SSec);
    IncKey = 1'b1; cyc(4); IncKey = 1'b0; cyc(4);
    ticks(39);
    n_cmp++; if (Mode !== 2'b11) begin n_err++; $display("FAIL tmo_early got=%b required=11", Mode); end
    n_cmp++; if (Run !== 1'b0) begin n_err++; $display("FAIL tmo_run_set got=%b required=0", Run); end
    n_cmp++; if (Blink !== 1'b0) begin n_err++; $display("FAIL tmo_blink_phase got=%b required=0", Blink); end
    Tick = 1'b1;
    cyc(1);
    Tick = 1'b0;
    n_cmp++; if (Mode !== 2'b00) begin n_err++; $display("FAIL tmo_mode_run got=%b required=00", Mode); end
    n_cmp++; if (Run !== 1'b1) begin n_err++; $display("FAIL tmo_run got=%b required=1", Run); end
    n_cmp++; if (Blink !== 1'b0) begin n_err++; $display("FAIL tmo_blink got=%b required=0", Blink); end
    cyc(3);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL tmo_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    mode_down(); mode_up();
    IncKey = 1'b1;
    cyc(3);
    n_cmp++; if (IncHr !== 1'b1) begin n_err++; $display("FAIL mid_strobe got=%b required=1", IncHr); end
    CR = 1'b1;
    #1;
    n_cmp++; if (IncHr !== 1'b0) begin n_err++; $display("FAIL mid_cut got=%b required=0", IncHr); end
    n_cmp++; if (Mode !== 2'b00) begin n_err++; $display("FAIL mid_mode got=%b required=00", Mode); end
    ModeKey = 1'b1;
    cyc(2);
    CR = 1'b0;
    cyc(10);
    n_cmp++; if (Mode !== 2'b00) begin n_err++; $display("FAIL held_after_reset got=%b required=00", Mode); end
    ModeKey = 1'b0;
    IncKey  = 1'b0;
    cyc(4);
    mode_down();
    n_cmp++; if (Mode !== 2'b01) begin n_err++; $display("FAIL repress_mode got=%b required=01", Mode); end
    mode_up();
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_single_inc();
    test_auto_repeat();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the digital clock datapath. It turns two debounced front-panel keys, Mode and Inc, into a set-mode state machine. The FSM issues single-cycle increment strobes to the hour and minute counters, a clear strobe for the seconds counter, and a run enable that freezes the seconds counter while seconds are being set. It sits between the panel debouncers and the clock counter chain; the counters' adjust inputs are driven only from here.

## Interface
- HOLD_TICKS, 4: Tick count Inc must be held before auto-repeat starts (≥1).
- REPEAT_TICKS, 1: Tick count between auto-repeat strobes (≥1).
- TIMEOUT_TICKS, 40: idle Tick count in a set mode before returning to RUN (≥1).
- CW, 6: width of the internal tick counters; must hold max(HOLD_TICKS, TIMEOUT_TICKS).
- CP  in  1  system clock, rising edge.
- CR  in  1  reset, asynchronous, active-high.
- Tick  in  1  single-CP-cycle enable at the panel rate (e.g. 4 Hz).
- ModeKey  in  1  debounced level, 1 = pressed, asynchronous to CP.
- IncKey  in  1  debounced level, 1 = pressed, asynchronous to CP.
- Mode  out  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC.
- IncHr  out  1  one-cycle hour increment strobe.
- IncMin  out  1  one-cycle minute increment strobe.
- ClrSec  out  1  one-cycle seconds clear strobe.
- Run  out  1  seconds-counter enable.
- Blink  out  1  display blink phase for the field being set.

## Operation
- Each key passes through a 2-flop synchronizer and a rising-edge detector. Only the synchronized level and its edge are used.
- FSM: RUN→SET_HR→SET_MIN→SET_SEC→RUN, advancing on each ModeKey edge.
- An IncKey edge produces one strobe for the current mode:
  - SET_HR: IncHr.
  - SET_MIN: IncMin.
  - SET_SEC: ClrSec.
  - RUN: ignored.
- Auto-repeat applies in SET_HR and SET_MIN only:
  - The hold counter clears on the IncKey edge and counts Ticks while the synchronized IncKey stays high.
  - When it reaches HOLD_TICKS, one strobe is issued.
  - After that, one strobe is issued every REPEAT_TICKS Ticks until release.
  - Release clears the hold counter.
- Idle timeout applies in any set mode:
  - The idle counter counts Ticks while both synchronized keys are low.
  - Any key edge, or a held IncKey, clears it.
  - On reaching TIMEOUT_TICKS, the FSM goes to RUN and the counter clears.
- Simultaneous ModeKey and IncKey edges: Mode wins. The FSM advances, no strobe is issued, and the hold counter clears.
- Any mode change clears the hold and idle counters. An IncKey held across a mode change does not repeat until it is released and pressed again.
- Run = 0 only in SET_SEC, otherwise 1.
- Blink = 0 in RUN. In set modes it toggles on each Tick; it is forced to 1 on entry to a set mode.
- Strobes are mutually exclusive, never exceed one cycle, and are never issued in RUN.
- Counter arithmetic is unsigned CW bits. Counters saturate at their compare value and never wrap.

## Timing
- Reset (CR high, asynchronous): Mode = 00, IncHr = IncMin = ClrSec = 0, Run = 1, Blink = 0. Synchronizers, edge registers and both counters clear.
- Outputs are all registered; there is no combinational path from any input to any output.
- Key latency: if the key is first sampled high at edge N, the edge is detected after N+1. Mode updates and any strobe is high for exactly one cycle, both starting at edge N+2.
- Tick-driven events (repeat strobe, timeout, Blink toggle) take effect at the edge after the CP cycle in which Tick is high.
- A repeat strobe and a timeout cannot coincide, because the idle counter is held clear while IncKey is high.
- CR asserted mid-strobe terminates the strobe immediately. After CR deasserts, keys already held must produce a new edge before they act.

## Structure
- Package clock_ctrl_pkg holds:
  - Mode encodings MODE_RUN, MODE_SET_HR, MODE_SET_MIN, MODE_SET_SEC.
  - The 2-bit mode type.
- Sub-module key_sync_edge holds the 2-flop synchronizer, previous-level register and rising-edge output. It has ports CP, CR, KeyIn, Level, Rise and is instantiated once per key.
- FSM, hold counter, idle counter and output registers live in clock_set_ctrl.

## Test plan
- Reset check: CR pulse with both keys low → Mode = 00, Run = 1, Blink = 0, all strobes 0.
- Mode cycling: 4 ModeKey presses → Mode steps 01, 10, 11, 00. Run is 0 only while Mode = 11.
- Single increment: in SET_MIN, one Inc press (released before HOLD_TICKS Ticks) → exactly one IncMin pulse two cycles after first sample, no IncHr or ClrSec.
- Auto-repeat: in SET_HR with HOLD_TICKS = 4, REPEAT_TICKS = 1, hold Inc for 10 Ticks → 1 + 7 = 8 IncHr pulses; nothing after release.
- Timeout: in SET_SEC with TIMEOUT_TICKS = 40 and no keys → Mode returns to 00 after the 40th Tick; Blink drops to 0 and Run returns to 1.
- Simultaneous edges: in SET_HR, assert ModeKey and IncKey on the same cycle → Mode = 10, no strobe. Keep Inc held for 20 Ticks → no IncMin pulses.
